sipo: RTL and testbench
=======================

# sipo

Serial-in/parallel-out deserializer that sits directly downstream of the `piso` serializer and consumes its bit stream. It takes `data_o`/`valid_o` from `piso` and returns `ready_i` to it. It assembles MSB-first bits into WIDTH-bit words and buffers them in a small FIFO. Words are presented on a parallel valid/ready interface.

## Interface
- `WIDTH`, 8, bits per word.
- `DEPTH`, 4, output FIFO entries; power of 2, ≥2.
- `TIMEOUT`, 16, consecutive `valid_i`-low cycles mid-word before the partial word is discarded.
- `sclk_i`  in  1  the only clock (serial bit clock); all logic on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `data_i`  in  1  serial bit, driven by piso `data_o`.
- `valid_i`  in  1  serial bit valid, driven by piso `valid_o`.
- `ready_o`  out  1  bit accept, drives piso `ready_i`; combinational from state only.
- `pdata_o`  out  WIDTH  FIFO head word.
- `pvalid_o`  out  1  FIFO not empty.
- `pready_i`  in  1  consumer accepts head word.
- `frame_err_o`  out  1  one-cycle pulse: a partial word was discarded.
- `level_o`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- A bit is accepted on an edge with `valid_i && ready_o`. A word is accepted on an edge with `pvalid_o && pready_i` (pop).
- Bit order: the first accepted bit becomes word bit WIDTH-1 (MSB first, matching piso).
- States (one-hot): S_IDLE=3'b001 (bit count 0), S_SHIFT=3'b010 (1..WIDTH-1 bits held), S_STALL=3'b100 (complete word waiting for FIFO space).
- `ready_o` = 1 in S_IDLE and S_SHIFT, and 0 in S_STALL.
- S_IDLE: an accepted bit loads the shift register and sets the count to 1, then moves to S_SHIFT.
- S_SHIFT, non-final bit: shift left, insert `data_i`, increment the count, and clear the idle counter.
- S_SHIFT, final (WIDTH-th) bit: the word is {sr[WIDTH-2:0], data_i}.
  - The word is pushed the same edge if the FIFO is not full, or if it is full and a pop occurs this edge. The state then goes to S_IDLE.
  - Otherwise the word is latched in a hold register and the state goes to S_STALL.
- S_STALL: the held word is pushed on the first edge where the FIFO is not full, or a pop occurs that edge. The state then goes to S_IDLE. `valid_i` is ignored in this state.
- Timeout:
  - In S_SHIFT, the idle counter increments on each edge with `valid_i`=0.
  - When it reaches TIMEOUT, the partial word is discarded, the state returns to S_IDLE, and `frame_err_o`=1 for that one cycle.
  - Any accepted bit clears the idle counter.
  - The idle counter does not run in S_IDLE or S_STALL.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - Push and pop on the same edge keep the level unchanged, including when the FIFO is full or holds 1 entry.
  - Pop when empty is impossible, because `pvalid_o`=0.
- Reset values: state S_IDLE, `ready_o`=1, `pvalid_o`=0, `pdata_o`=0, `frame_err_o`=0, `level_o`=0. Shift register, counters and FIFO pointers are 0.
- Reset mid-word or mid-stall discards all data with no `frame_err_o` pulse.

## Timing
- Latency: final bit accepted at edge N → `pvalid_o`=1 and `pdata_o` valid after edge N, provided the FIFO was empty.
- `pdata_o` is the registered head entry. It is stable while `pvalid_o && !pready_i`.
- Throughput: one bit per cycle sustained, with no bubble between words while the FIFO has space.
- `ready_o` drops the cycle after the edge entering S_STALL. It rises the cycle after the edge that pushes the held word.
- `frame_err_o` asserts the cycle after the TIMEOUT-th idle edge.

## Structure
- Package `sipo_pkg`:
  - State encodings S_IDLE, S_SHIFT, S_STALL.
  - Default WIDTH, DEPTH and TIMEOUT constants.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - Ports: push/wdata, pop/rdata, full, empty, level.
  - Same clock and synchronous reset.
- `sipo` contains the FSM, shift register, bit counter, idle counter and hold register.

## Test plan
- Single word: shift bits 1,0,1,0,0,1,0,1 with `pready_i`=1 → `pdata_o`=8'hA5 with `pvalid_o` high one cycle after the 8th bit edge; `level_o` returns to 0.
- Back-pressure:
  - Stimulus: `pready_i`=0, then 5 back-to-back words 8'h01..8'h05.
  - Level 4 after word 4.
  - The 5th word enters S_STALL with `ready_o`=0.
  - Assert `pready_i`=1 → pops 8'h01..8'h05 in order, and `ready_o` returns to 1.
- Full with simultaneous pop: FIFO full, final bit accepted on the same edge as a pop → no stall, level stays 4.
- Timeout: 3 bits, then `valid_i`=0 for 16 cycles → one `frame_err_o` pulse, no push. The next 8 bits 8'h3C arrive intact.
- Gapped bits: `valid_i` low for 15 cycles between bits 4 and 5 of 8'hC3 → no error, word 8'hC3 delivered.
- Reset: assert `rst_i` after 5 bits and in S_STALL → all outputs at reset values next cycle. The next word 8'h5A is correctly aligned.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel deserializer.
package sipo_pkg;

    // One-hot FSM encoding
    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_SHIFT = 3'b010,
        S_STALL = 3'b100
    } state_t;

    localparam int WIDTH_DEF   = 8;
    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/sipo_if.sv
// Serial bit input plus parallel word output of the deserializer.
interface sipo_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    logic                     data_i;
    logic                     valid_i;
    logic                     ready_o;
    logic [WIDTH-1:0]         pdata_o;
    logic                     pvalid_o;
    logic                     pready_i;
    logic                     frame_err_o;
    logic [$clog2(DEPTH):0]   level_o;

    // Deserializer side
    modport slave (
        input  data_i, valid_i, pready_i,
        output ready_o, pdata_o, pvalid_o, frame_err_o, level_o
    );

    // Serializer / consumer side
    modport master (
        output data_i, valid_i, pready_i,
        input  ready_o, pdata_o, pvalid_o, frame_err_o, level_o
    );
endinterface

// File: rtl/sipo_sync_fifo.sv
// Small synchronous FIFO; head entry is read straight from the storage
// registers so it stays stable until popped.
module sync_fifo
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Storage and pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/sipo.sv
// Serial-in/parallel-out deserializer: assembles MSB-first bits into words,
// buffers them in a FIFO and discards partial words after a silence timeout.
module sipo
    import sipo_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic  sclk_i,
    input  logic  rst_i,
    sipo_if.slave bus
);
    localparam int SRW = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int IW  = $clog2(TIMEOUT + 1);

    state_t                 state;
    logic [SRW-1:0]         sr;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idle;
    logic [WIDTH-1:0]       hold;
    logic                   frame_err;

    logic                   push;
    logic [WIDTH-1:0]       wdata;
    logic [WIDTH-1:0]       word;
    logic [WIDTH-1:0]       rdata;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] level;
    logic                   pop;
    logic                   can_push;
    logic                   last_bit;

    // A full FIFO still has room for a word when the head leaves this edge
    assign pop      = bus.pready_i && !empty;
    assign can_push = !full || pop;
    assign word     = {sr, bus.data_i};
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Select what (if anything) enters the FIFO this edge
    always_comb begin
        push  = 1'b0;
        wdata = word;
        unique case (state)
            S_SHIFT: push = bus.valid_i && last_bit && can_push;
            S_STALL: begin
                push  = can_push;
                wdata = hold;
            end
            default: ;
        endcase
    end

    // FSM with shift register, bit counter, idle counter and hold register
    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            sr        <= '0;
            cnt       <= '0;
            idle      <= '0;
            hold      <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.valid_i) begin
                        sr    <= SRW'(bus.data_i);
                        cnt   <= CW'(1);
                        idle  <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bus.valid_i) begin
                        idle <= '0;
                        if (last_bit) begin
                            cnt <= '0;
                            if (can_push) begin
                                state <= S_IDLE;
                            end else begin
                                hold  <= word;
                                state <= S_STALL;
                            end
                        end else begin
                            sr  <= word[SRW-1:0];
                            cnt <= cnt + 1'b1;
                        end
                    end else if (idle == IW'(TIMEOUT - 1)) begin
                        idle      <= '0;
                        cnt       <= '0;
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        idle <= idle + 1'b1;
                    end
                end
                S_STALL: begin
                    if (can_push) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (sclk_i),
        .rst   (rst_i),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign bus.ready_o     = (state != S_STALL);
    assign bus.pvalid_o    = !empty;
    assign bus.pdata_o     = rdata;
    assign bus.level_o     = level;
    assign bus.frame_err_o = frame_err;
endmodule

// File: tb/tb_sipo.sv
// Testbench for sipo: directed scenarios followed by randomized traffic,
// every cycle checked against a queue-based behavioural model.
module tb_sipo;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sipo_if #(.WIDTH(W), .DEPTH(D)) bus ();

    sipo #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .sclk_i (clk),
        .rst_i  (rst),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [W-1:0] m_q[$];
    int           m_nbits;
    logic [W-1:0] m_part;
    int           m_idle;
    bit           m_hold;
    logic [W-1:0] m_hold_w;
    bit           m_ferr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_nbits  = 0;
        m_part   = '0;
        m_idle   = 0;
        m_hold   = 0;
        m_hold_w = '0;
        m_ferr   = 0;
    endtask

    task automatic model_edge(input bit v, input bit d, input bit pr);
        bit was_full;
        bit pop;
        bit room;
        was_full = (m_q.size() == D);
        pop      = (m_q.size() > 0) && pr;
        room     = !was_full || pop;
        m_ferr   = 0;
        if (pop) void'(m_q.pop_front());
        if (m_hold) begin
            if (room) begin
                m_q.push_back(m_hold_w);
                m_hold = 0;
            end
        end else if (v) begin
            m_part = (m_part << 1) | W'(d);
            m_nbits++;
            m_idle = 0;
            if (m_nbits == W) begin
                m_nbits = 0;
                if (room) m_q.push_back(m_part);
                else begin
                    m_hold   = 1;
                    m_hold_w = m_part;
                end
                m_part = '0;
            end
        end else if (m_nbits > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_nbits = 0;
                m_idle  = 0;
                m_part  = '0;
                m_ferr  = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("ready_o", 32'(bus.ready_o), 32'(!m_hold));
        chk("pvalid_o", 32'(bus.pvalid_o), 32'(m_q.size() > 0));
        chk("level_o", 32'(bus.level_o), 32'(m_q.size()));
        chk("frame_err_o", 32'(bus.frame_err_o), 32'(m_ferr));
        if (m_q.size() > 0) chk("pdata_o", 32'(bus.pdata_o), 32'(m_q[0]));
    endtask

    task automatic cyc(input bit v, input bit d, input bit pr);
        bus.valid_i  = v;
        bus.data_i   = d;
        bus.pready_i = pr;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(v, d, pr);
        #1;
        check_all();
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit pr);
        for (int i = W - 1; i >= 0; i--) cyc(1'b1, w[i], pr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_pdata", 32'(bus.pdata_o), 32'h0);
        chk("rst_ready", 32'(bus.ready_o), 32'h1);
        chk("rst_level", 32'(bus.level_o), 32'h0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [W-1:0] w;
        int pv;
        int pp;
        bus.valid_i  = 1'b0;
        bus.data_i   = 1'b0;
        bus.pready_i = 1'b0;
        model_reset();

        do_reset();

        // Single word A5 with consumer ready
        send_word(8'hA5, 1'b1);
        chk("single_pvalid", 32'(bus.pvalid_o), 32'h1);
        chk("single_pdata", 32'(bus.pdata_o), 32'hA5);
        cyc(1'b0, 1'b0, 1'b1);
        chk("single_level", 32'(bus.level_o), 32'h0);

        // Back-pressure: five words into a four-entry FIFO
        for (int k = 1; k <= 5; k++) begin
            w = W'(k);
            send_word(w, 1'b0);
            if (k == 4) chk("bp_level4", 32'(bus.level_o), 32'h4);
        end
        chk("bp_stall_ready", 32'(bus.ready_o), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            chk("bp_order", 32'(bus.pdata_o), 32'(k));
            cyc(1'b0, 1'b0, 1'b1);
        end
        chk("bp_ready_back", 32'(bus.ready_o), 32'h1);
        chk("bp_empty", 32'(bus.level_o), 32'h0);

        // Full FIFO with a pop on the final-bit edge
        for (int k = 0; k < 4; k++) begin
            w = 8'h10 + W'(k);
            send_word(w, 1'b0);
        end
        w = 8'h99;
        for (int i = W - 1; i >= 1; i--) cyc(1'b1, w[i], 1'b0);
        cyc(1'b1, w[0], 1'b1);
        chk("fullpop_ready", 32'(bus.ready_o), 32'h1);
        chk("fullpop_level", 32'(bus.level_o), 32'h4);
        drain(5);

        // Timeout after three bits
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < TO - 1; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("to_no_err_early", 32'(bus.frame_err_o), 32'h0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("to_err_pulse", 32'(bus.frame_err_o), 32'h1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("to_err_clear", 32'(bus.frame_err_o), 32'h0);
        chk("to_no_push", 32'(bus.level_o), 32'h0);
        send_word(8'h3C, 1'b0);
        chk("to_next_word", 32'(bus.pdata_o), 32'h3C);
        drain(2);

        // Gap of TIMEOUT-1 idle cycles mid-word is tolerated
        w = 8'hC3;
        for (int i = W - 1; i >= 4; i--) cyc(1'b1, w[i], 1'b0);
        for (int i = 0; i < TO - 1; i++) cyc(1'b0, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) cyc(1'b1, w[i], 1'b0);
        chk("gap_pdata", 32'(bus.pdata_o), 32'hC3);
        chk("gap_level", 32'(bus.level_o), 32'h1);
        drain(2);

        // Reset after five bits
        w = 8'hFF;
        for (int i = W - 1; i >= 3; i--) cyc(1'b1, w[i], 1'b0);
        do_reset();
        // Reset while stalled
        for (int k = 1; k <= 5; k++) begin
            w = 8'h20 + W'(k);
            send_word(w, 1'b0);
        end
        chk("rst_stall_pre", 32'(bus.ready_o), 32'h0);
        do_reset();
        send_word(8'h5A, 1'b0);
        chk("rst_realign", 32'(bus.pdata_o), 32'h5A);
        chk("rst_realign_lvl", 32'(bus.level_o), 32'h1);
        drain(2);

        // Randomized traffic in phases of varying bit and consumer rates
        for (int ph = 0; ph < 6; ph++) begin
            pv = 40 + 12 * ph;
            pp = 90 - 15 * ph;
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 149) == 0) begin
                    int gap;
                    gap = $urandom_range(TO - 3, TO + 3);
                    for (int g = 0; g < gap; g++)
                        cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < pp));
                end else begin
                    cyc(1'($urandom_range(0, 99) < pv), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 99) < pp));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
